regfile_param: RTL
==================

Name: regfile_param

Overview:
Parametrised register file succeeding the single-cycle MIPS register file.
- Clocked write port with byte enables.
- Two asynchronous read ports with optional write-to-read bypass.
- Optional hardwired-zero register 0.
- Per-register pending-write scoreboard, so a multi-cycle datapath can detect RAW hazards on outstanding loads.
- Sits between decode (read/scoreboard set) and writeback (write/scoreboard clear).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, register index width; depth = 2**ADDR_W.
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and never becomes busy.
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset.
read_reg_num_1  input  ADDR_W  read port 1 index.
read_reg_num_2  input  ADDR_W  read port 2 index.
read_data_1  output  DATA_W  read port 1 data (combinational).
read_data_2  output  DATA_W  read port 2 data (combinational).
read_busy_1  output  1  scoreboard bit of read_reg_num_1 (combinational).
read_busy_2  output  1  scoreboard bit of read_reg_num_2 (combinational).
RegWrite  input  1  write enable.
write_reg_num  input  ADDR_W  write index.
write_data  input  DATA_W  write data.
write_be  input  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
sb_set  input  1  mark sb_set_num pending.
sb_set_num  input  ADDR_W  register index to mark pending.
busy_any  output  1  OR of all scoreboard bits.

Behaviour:
- Reset (reset==0 at rising edge):
  - All registers become 0 and all scoreboard bits become 0.
  - Reset overrides RegWrite and sb_set in the same cycle.
  - After reset: read_data_* = 0, read_busy_* = 0, busy_any = 0.
- Write:
  - Takes effect when reset==1 and RegWrite==1 at the rising edge.
  - Each byte of write_reg_num with write_be[k]==1 takes write_data's corresponding byte; other bytes hold.
  - write_be == 0 with RegWrite==1 changes no data but still clears the scoreboard bit.
- Read: read_data_n = stored value of read_reg_num_n, with no clock latency.
- Bypass (BYPASS=1):
  - Condition: RegWrite==1 and write_reg_num==read_reg_num_n (and not ZERO_REG index 0).
  - read_data_n returns the merged value: new bytes where write_be is set, stored bytes elsewhere.
  - BYPASS=0: read returns the pre-edge stored value.
- Zero register (ZERO_REG=1):
  - Index 0 reads 0 on both data and busy outputs.
  - Writes and sb_set targeting index 0 are ignored.
- Scoreboard:
  - At the edge, sb_set==1 sets bit[sb_set_num].
  - RegWrite==1 clears bit[write_reg_num].
  - Same index set and cleared in the same cycle: set wins (a new producer was issued), and data is still written.
  - Different indices: both actions occur.
  - read_busy_n reflects stored bits only, not bypassed; a register being written this cycle shows busy until the edge.
  - busy_any is combinational OR of stored bits.
- Both read ports may address the same register; outputs are identical.
- Reset mid-operation: any pending writes and scoreboard state are discarded.
- Out-of-range indices cannot occur (depth = 2**ADDR_W).

Test Plan:
1. Reset: hold reset=0 for 2 cycles after writing 0xDEADBEEF to r5 → read r5 = 0x00000000, busy_any=0.
2. Byte write: write r3=0x11223344 with be=4'b1111, then 0xAABBCCDD with be=4'b0101 → r3 reads 0x11BB33DD.
3. Bypass: in the same cycle, RegWrite=1, write_reg_num=7, data=0x0000CAFE, read_reg_num_1=7, r7 previously 0x1 → read_data_1=0x0000CAFE before the edge with BYPASS=1; 0x00000001 with BYPASS=0.
4. Zero register: write r0=0xFFFFFFFF and sb_set r0 → read r0 = 0, read_busy=0, busy_any=0.
5. Scoreboard: sb_set r9 → read_busy=1, busy_any=1; next cycle RegWrite r9 → busy clears after the edge. Separately, sb_set r9 and RegWrite r9 in the same cycle → bit stays 1 and data is updated.
6. Parametrisation: DATA_W=64, ADDR_W=3 → write r7 with be=8'h80, data=0xAB00000000000000 → only the top byte changes; busy tracked for 8 registers.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file with byte-enabled write port, two combinational
// read ports with optional write bypass, optional zero register and a pending-write scoreboard.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   read_reg_num_1,
   input  logic [ADDR_W-1:0]   read_reg_num_2,
   output logic [DATA_W-1:0]   read_data_1,
   output logic [DATA_W-1:0]   read_data_2,
   output logic                read_busy_1,
   output logic                read_busy_2,
   input  logic                RegWrite,
   input  logic [ADDR_W-1:0]   write_reg_num,
   input  logic [DATA_W-1:0]   write_data,
   input  logic [DATA_W/8-1:0] write_be,
   input  logic                sb_set,
   input  logic [ADDR_W-1:0]   sb_set_num,
   output logic                busy_any
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int NBYTES = DATA_W/8;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;
   logic              wr_en;
   logic              set_en;
   logic [DATA_W-1:0] wr_merged;

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                      input logic [DATA_W-1:0] new_val,
                                                      input logic [NBYTES-1:0] be);
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int k = 0; k < NBYTES; k++) begin
         if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
      end
      return res;
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
      return (ZERO_REG != 0) && (idx == '0);
   endfunction

   assign wr_en     = RegWrite && !is_zero_reg(write_reg_num);
   assign set_en    = sb_set && !is_zero_reg(sb_set_num);
   assign wr_merged = merge_bytes(regs[write_reg_num], write_data, write_be);

   // Clear first, then set, so a newly issued producer wins over a same-cycle writeback.
   always_comb begin
      busy_next = busy;
      if (wr_en)  busy_next[write_reg_num] = 1'b0;
      if (set_en) busy_next[sb_set_num]    = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_en) regs[write_reg_num] <= wr_merged;
         busy <= busy_next;
      end
   end

   always_comb begin
      read_data_1 = regs[read_reg_num_1];
      if ((BYPASS != 0) && wr_en && (write_reg_num == read_reg_num_1)) read_data_1 = wr_merged;
      if (is_zero_reg(read_reg_num_1)) read_data_1 = '0;
   end

   always_comb begin
      read_data_2 = regs[read_reg_num_2];
      if ((BYPASS != 0) && wr_en && (write_reg_num == read_reg_num_2)) read_data_2 = wr_merged;
      if (is_zero_reg(read_reg_num_2)) read_data_2 = '0;
   end

   // Busy reflects stored scoreboard state only; bypassed writes stay busy until the edge.
   assign read_busy_1 = busy[read_reg_num_1] && !is_zero_reg(read_reg_num_1);
   assign read_busy_2 = busy[read_reg_num_2] && !is_zero_reg(read_reg_num_2);
   assign busy_any    = |busy;

endmodule
